// File: rtl/blctrl_scheduler.sv
// -----------------------------------------------------------------------------
// blctrl_scheduler
//   Shares one I2C master between up to eight BL-Ctrl ESCs. Every refresh tick
//   the per-motor speeds and enable mask are snapshotted, then one 2-byte write
//   (address, throttle) is issued per enabled motor in ascending index order.
//   Per-motor ACK results are collected into nack_mask at the end of the frame.
//   A stalled transaction is abandoned after TIMEOUT_CYCLES. Zero throttle is
//   sent once speed_update has been missing for STALE_FRAMES ticks.
//
//   Command handshake: cmd_valid is held high with cmd_addr/cmd_data stable
//   until the cycle in which cmd_ready is also high; that cycle is the single
//   transfer. cmd_valid is low again on the following cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   master_enable       enables the tick counter and scheduling
//   motor_enable[7:0]   per-motor enable
//   target_speed_flat   motor i speed in bits [8i+7:8i]
//   speed_update        one-cycle pulse, fresh speeds available
//   cmd_valid/ready     command handshake to the I2C master
//   cmd_addr, cmd_data  7-bit slave address and throttle byte
//   done, ack_err       transaction finished; ack_err=1 means NACK
//   busy                frame in progress
//   frame_done          one-cycle pulse at end of a completed frame
//   nack_mask[7:0]      failure bits of the last completed frame
//   overrun             one-cycle pulse when a tick hits a running frame
//   failsafe            speeds are stale, zeros are being sent
//   fsm_state[2:0]      current scheduler state, for observation only
// -----------------------------------------------------------------------------
module blctrl_scheduler #(
  parameter int         CLK_HZ         = 16000000,
  parameter int         REFRESH_HZ     = 500,
  parameter logic [6:0] BASE_ADDR      = 7'h29,
  parameter int         TIMEOUT_CYCLES = 8000,
  parameter int         STALE_FRAMES   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        master_enable,
  input  logic [7:0]  motor_enable,
  input  logic [63:0] target_speed_flat,
  input  logic        speed_update,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_addr,
  output logic [7:0]  cmd_data,
  input  logic        done,
  input  logic        ack_err,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  nack_mask,
  output logic        overrun,
  output logic        failsafe,
  output logic [2:0]  fsm_state
);

  localparam int PERIOD = CLK_HZ / REFRESH_HZ;
  localparam int PW     = $clog2(PERIOD);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW     = $clog2(STALE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FEND  = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [PW-1:0]  tick_cnt;
  logic           tick;
  logic [SW-1:0]  stale_cnt;
  logic [TW-1:0]  wait_cnt;
  logic           wait_expired;
  logic [7:0]     snap_en;
  logic [63:0]    snap_spd;
  logic [3:0]     idx;       // next index to search from; 8 means "past motor 7"
  logic [2:0]     cur;       // motor currently being served
  logic [7:0]     acc;       // nack bits of the frame in progress
  logic           found;
  logic [2:0]     fidx;

  assign tick         = master_enable && (tick_cnt == PW'(PERIOD - 1));
  assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign failsafe     = (stale_cnt == SW'(STALE_FRAMES));
  assign cmd_valid    = (state == S_ISSUE);
  assign frame_done   = (state == S_FEND);
  assign fsm_state    = state;

  // Lowest enabled motor at or above idx in the frozen mask.
  always_comb begin
    found = 1'b0;
    fidx  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (snap_en[k] && (k >= int'(idx))) begin
        found = 1'b1;
        fidx  = 3'(k);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (tick) state_n = S_SCAN;
      // Dropping master_enable aborts the frame here, after any in-flight
      // transaction has completed, so no frame_done and no nack_mask update.
      S_SCAN: begin
        if (!master_enable) state_n = S_IDLE;
        else if (found)     state_n = S_ISSUE;
        else                state_n = S_FEND;
      end
      S_ISSUE: if (cmd_ready) state_n = S_WAIT;
      S_WAIT:  if (done || wait_expired) state_n = S_SCAN;
      S_FEND:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      stale_cnt <= SW'(STALE_FRAMES);
      wait_cnt  <= '0;
      snap_en   <= '0;
      snap_spd  <= '0;
      idx       <= '0;
      cur       <= '0;
      acc       <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      nack_mask <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_n;

      if (!master_enable || tick) tick_cnt <= '0;
      else                        tick_cnt <= tick_cnt + PW'(1);

      // A fresh update in the same cycle as a tick leaves the counter clear.
      if (speed_update)                                 stale_cnt <= '0;
      else if (tick && stale_cnt != SW'(STALE_FRAMES)) stale_cnt <= stale_cnt + SW'(1);

      // busy covers SCAN (after the first), ISSUE, WAIT and FEND, but not the
      // SCAN that leads straight back to IDLE on an abort.
      busy    <= (state != S_IDLE) && (state_n != S_IDLE);
      overrun <= tick && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (tick) begin
            snap_en  <= motor_enable;
            snap_spd <= failsafe ? 64'd0 : target_speed_flat;
            idx      <= 4'd0;
            acc      <= 8'd0;
          end
        end
        S_SCAN: begin
          if (master_enable && found) begin
            cur      <= fidx;
            cmd_addr <= BASE_ADDR + {4'b0000, fidx};
            cmd_data <= snap_spd[{fidx, 3'b000} +: 8];
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (done) begin
            acc[cur] <= ack_err;
            idx      <= {1'b0, cur} + 4'd1;
          end else if (wait_expired) begin
            acc[cur] <= 1'b1;
            idx      <= {1'b0, cur} + 4'd1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_FEND: nack_mask <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blctrl_scheduler.sv
// -----------------------------------------------------------------------------
// tb_blctrl_scheduler
//   Directed bench for blctrl_scheduler. A timestamp/queue model derives the
//   expected command stream, frame_done, nack_mask, busy, overrun and failsafe
//   from the frame rules and is compared against the DUT on every negedge.
//   Literal expectations per test pin the model.
// -----------------------------------------------------------------------------
module tb_blctrl_scheduler;

  localparam int         CLK_HZ  = 1000;
  localparam int         REF_HZ  = 10;
  localparam int         P       = CLK_HZ / REF_HZ;
  localparam int         TO      = 50;
  localparam int         STALE   = 3;
  localparam logic [6:0] BASE    = 7'h29;
  localparam logic [63:0] SPEEDS = 64'hC866554433221140;

  logic        clk, rst_n, master_enable, speed_update, cmd_ready, done, ack_err;
  logic [7:0]  motor_enable;
  logic [63:0] target_speed_flat;
  logic        cmd_valid, busy, frame_done, overrun, failsafe;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_data, nack_mask;
  logic [2:0]  fsm_state;

  blctrl_scheduler #(
    .CLK_HZ(CLK_HZ), .REFRESH_HZ(REF_HZ), .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(TO), .STALE_FRAMES(STALE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .master_enable(master_enable),
    .motor_enable(motor_enable), .target_speed_flat(target_speed_flat),
    .speed_update(speed_update), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done(done), .ack_err(ack_err),
    .busy(busy), .frame_done(frame_done), .nack_mask(nack_mask),
    .overrun(overrun), .failsafe(failsafe), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  logic [14:0] got_q[$];   // accepted {addr, data}
  int fd_cnt  = 0;
  int ovr_cnt = 0;

  // ---------------- I2C master responder ----------------
  int         done_delay = 5;
  logic [7:0] nack_sel   = 8'h00;
  logic [7:0] hold_sel   = 8'h00;
  int         stray_req  = 0;
  int         stray_ack  = 0;

  initial begin
    done    = 1'b0;
    ack_err = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_ack) begin
        stray_ack++;
        @(posedge clk); #1;
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
      end else if (rst_n && cmd_valid && cmd_ready) begin
        int m;
        m = int'(cmd_addr) - int'(BASE);
        if (!hold_sel[m]) begin
          @(posedge clk);
          repeat (done_delay - 1) @(posedge clk);
          #1;
          done    = 1'b1;
          ack_err = nack_sel[m];
          @(posedge clk); #1;
          done    = 1'b0;
          ack_err = 1'b0;
        end
      end
    end
  end

  // ---------------- model + scoreboard ----------------
  logic [14:0] exp_q[$];   // commands still owed in the current frame
  int   cyc, ph, stale, t_start, scan_at, issue_from, wait_from, fend_at, cur_m;
  bit   frame_on, in_txn, ovr_exp;
  logic [7:0] acc_m, mask_m;

  always @(negedge clk) begin
    bit exp_valid, tk, fo;
    if (!rst_n) begin
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_cmd_addr", cmd_addr, 7'h00);
      check("rst_cmd_data", cmd_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_nack_mask", nack_mask, 8'h00);
      check("rst_failsafe", failsafe, 1'b1);
      cyc = 0; ph = 0; stale = STALE; frame_on = 0; in_txn = 0; ovr_exp = 0;
      t_start = 0; scan_at = -1; issue_from = -1; wait_from = -1; fend_at = -1;
      cur_m = 0; acc_m = 0; mask_m = 0;
      exp_q.delete();
    end else begin
      exp_valid = (issue_from >= 0) && (cyc >= issue_from);
      check("cmd_valid", cmd_valid, exp_valid);
      if (exp_valid) check("cmd_addr_data", {cmd_addr, cmd_data}, exp_q[0]);
      check("frame_done", frame_done, cyc == fend_at);
      check("nack_mask", nack_mask, mask_m);
      check("failsafe", failsafe, stale == STALE);
      check("overrun", overrun, ovr_exp);
      check("busy", busy, frame_on && (cyc >= t_start + 2));

      if (frame_done) fd_cnt++;
      if (overrun) ovr_cnt++;
      if (cmd_valid && cmd_ready) got_q.push_back({cmd_addr, cmd_data});

      fo = frame_on;
      tk = master_enable && (ph == P - 1);

      if (exp_valid && cmd_ready) begin
        cur_m = int'(exp_q[0][14:8]) - int'(BASE);
        void'(exp_q.pop_front());
        issue_from = -1;
        wait_from  = cyc + 1;
        in_txn     = 1;
      end else if (in_txn && cyc >= wait_from) begin
        if (done) begin
          acc_m[cur_m] = ack_err; in_txn = 0; scan_at = cyc + 1;
        end else if (cyc - wait_from == TO - 1) begin
          acc_m[cur_m] = 1'b1;    in_txn = 0; scan_at = cyc + 1;
        end
      end

      if (cyc == scan_at) begin
        if (!master_enable) begin
          frame_on = 0;
          exp_q.delete();
        end else if (exp_q.size() > 0) issue_from = cyc + 1;
        else                           fend_at    = cyc + 1;
      end

      if (cyc == fend_at) begin
        mask_m   = acc_m;
        frame_on = 0;
      end

      ovr_exp = tk && fo;
      if (tk && !fo) begin
        frame_on = 1; t_start = cyc; acc_m = 8'h00; scan_at = cyc + 1;
        exp_q.delete();
        for (int i = 0; i < 8; i++)
          if (motor_enable[i])
            exp_q.push_back({BASE + 7'(i), (stale == STALE) ? 8'h00 : target_speed_flat[8*i +: 8]});
      end

      if (!master_enable)  ph = 0;
      else if (ph == P - 1) ph = 0;
      else                  ph = ph + 1;

      if (speed_update)              stale = 0;
      else if (tk && stale < STALE)  stale = stale + 1;

      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_update();
    speed_update = 1'b1;
    step(1);
    speed_update = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int limit);
    int start = fd_cnt;
    int k = 0;
    while (fd_cnt == start && k < limit) begin
      step(1);
      k++;
    end
    check(name, fd_cnt != start, 1'b1);
  endtask

  task automatic wait_valid_addr(input string name, input logic [6:0] addr, input int limit);
    int k = 0;
    while (!(cmd_valid && cmd_addr == addr) && k < limit) begin
      step(1);
      k++;
    end
    check(name, cmd_valid && cmd_addr == addr, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int o0, f0;
    rst_n = 1'b0; master_enable = 1'b0; motor_enable = 8'h00;
    target_speed_flat = SPEEDS; speed_update = 1'b0; cmd_ready = 1'b1;
    step(3);
    rst_n = 1'b1;

    // 1: reset state, stale speeds force zeros
    motor_enable  = 8'h81;
    master_enable = 1'b1;
    wait_frame("t1_frame_done", 300);
    check("t1_failsafe", failsafe, 1'b1);
    check("t1_cmd_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t1_cmd0", got_q[0], {7'h29, 8'h00});
      check("t1_cmd1", got_q[1], {7'h30, 8'h00});
    end
    check("t1_nack", nack_mask, 8'h00);

    // 2: normal frame with fresh speeds
    got_q.delete();
    pulse_update();
    check("t2_failsafe_clear", failsafe, 1'b0);
    wait_frame("t2_frame_done", 300);
    check("t2_cmd_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_cmd0", got_q[0], {7'h29, 8'h40});
      check("t2_cmd1", got_q[1], {7'h30, 8'hC8});
    end
    check("t2_failsafe", failsafe, 1'b0);

    // 3a: NACK on motor 7
    nack_sel = 8'h80;
    got_q.delete();
    pulse_update();
    wait_frame("t3a_frame_done", 300);
    check("t3a_nack", nack_mask, 8'h80);
    nack_sel = 8'h00;

    // 3b: motor 0 never answers, times out; motor 7 still served
    hold_sel = 8'h01;
    got_q.delete();
    pulse_update();
    wait_frame("t3b_frame_done", 300);
    check("t3b_nack", nack_mask, 8'h01);
    check("t3b_cmd_count", got_q.size(), 2);
    if (got_q.size() == 2) check("t3b_cmd1", got_q[1], {7'h30, 8'hC8});
    hold_sel = 8'h00;

    // empty mask frame, plus a stray done while idle
    motor_enable = 8'h00;
    stray_req++;
    got_q.delete();
    pulse_update();
    wait_frame("te_frame_done", 300);
    check("te_nack", nack_mask, 8'h00);
    check("te_cmd_count", got_q.size(), 0);
    motor_enable = 8'h81;

    // 4: backpressure, ready withheld for 10 cycles
    cmd_ready = 1'b0;
    got_q.delete();
    pulse_update();
    wait_valid_addr("t4_valid_seen", 7'h29, 300);
    step(10);
    check("t4_held_valid", cmd_valid, 1'b1);
    check("t4_held_addr_data", {cmd_addr, cmd_data}, {7'h29, 8'h40});
    check("t4_no_accept", got_q.size(), 0);
    cmd_ready = 1'b1;
    wait_frame("t4_frame_done", 300);
    check("t4_cmd_count", got_q.size(), 2);
    if (got_q.size() == 2) check("t4_cmd0", got_q[0], {7'h29, 8'h40});

    // 5: slow transactions make the frame overrun the next tick
    motor_enable = 8'h07;
    done_delay   = 45;
    o0 = ovr_cnt;
    got_q.delete();
    pulse_update();
    wait_frame("t5_frame_done", 400);
    check("t5_overrun_count", ovr_cnt - o0, 1);
    check("t5_cmd_count", got_q.size(), 3);
    if (got_q.size() == 3) check("t5_cmd2", got_q[2], {7'h2B, 8'h22});
    done_delay = 5;

    // 6a: master_enable drops during motor 1's transaction
    got_q.delete();
    f0 = fd_cnt;
    pulse_update();
    wait_valid_addr("t6_m1_valid", 7'h2A, 300);
    step(2);
    master_enable = 1'b0;
    step(30);
    check("t6_cmd_count", got_q.size(), 2);
    if (got_q.size() == 2) check("t6_cmd1", got_q[1], {7'h2A, 8'h11});
    check("t6_no_frame_done", fd_cnt - f0, 0);
    check("t6_nack_kept", nack_mask, 8'h00);
    check("t6_busy", busy, 1'b0);

    // 6b: re-enable with no updates; third frame must send zeros
    master_enable = 1'b1;
    wait_frame("t6_frame_a", 300);
    wait_frame("t6_frame_b", 300);
    got_q.delete();
    wait_frame("t6_frame_c", 300);
    check("t6_failsafe", failsafe, 1'b1);
    check("t6_cmd_count_fs", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t6_fs_cmd0", got_q[0], {7'h29, 8'h00});
      check("t6_fs_cmd2", got_q[2], {7'h2B, 8'h00});
    end

    step(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
